// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int unsigned DATA_W_MIN     = 5;
  localparam int unsigned DATA_W_MAX     = 9;
  localparam int unsigned OVERSAMPLE_MIN = 8;
  localparam int unsigned OVERSAMPLE_MAX = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Parity check: data zero-extended to DATA_W_MAX (extra zeros do not change the XOR).
  function automatic logic parity_err(input logic [DATA_W_MAX-1:0] data,
                                      input logic                  par_bit,
                                      input logic                  odd);
    return ((^data) ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// UART RX front end: 2-flop synchroniser, oversample tick counter and bit sampler.
// UART_RX_MAJORITY_VOTE_EN: decide each bit by 2-of-3 vote around mid-bit.
module uart_rx_sampler #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic baud_tick,
  input  logic rx,
  input  logic clr,
  input  logic start_phase,
  output logic rx_sync,
  output logic sample_stb_c,
  output logic sample_bit_c
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int unsigned HALF_TERM = OVERSAMPLE / 2 + 1;
`else
  localparam int unsigned HALF_TERM = OVERSAMPLE / 2;
`endif
  localparam int unsigned FULL_TERM = OVERSAMPLE;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term_last;

  assign rx_sync   = sync_q[1];
  assign term_last = start_phase ? CNT_W'(HALF_TERM - 1) : CNT_W'(FULL_TERM - 1);

  // Synchronise the async line; resets to idle-high so no false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  // Tick counter: restarts at each sample point, held clear while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (baud_tick)  cnt <= (cnt == term_last) ? '0 : cnt + CNT_W'(1);
  end

  assign sample_stb_c = baud_tick && !clr && (cnt == term_last);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote0;
  logic vote1;

  // Capture the two samples preceding the decision tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote0 <= 1'b1;
      vote1 <= 1'b1;
    end else if (baud_tick && !clr) begin
      if (cnt == term_last - CNT_W'(2)) vote0 <= rx_sync;
      if (cnt == term_last - CNT_W'(1)) vote1 <= rx_sync;
    end
  end

  assign sample_bit_c = (vote0 & vote1) | (vote0 & rx_sync) | (vote1 & rx_sync);
`else
  assign sample_bit_c = rx_sync;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, deserialiser, parity/stop checks, valid/ready output.
// Build option UART_RX_MAJORITY_VOTE_EN selects 3-sample majority bit decisions in the sampler.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_baud_tick,
  input  logic              i_rx,
  input  logic              i_parity_en,
  input  logic              i_parity_odd,
  input  logic              i_two_stop,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int unsigned BCNT_W = $clog2(DATA_W + 1);

  rx_state_t          state, state_n;
  logic [DATA_W-1:0]  shreg, shreg_n;
  logic [BCNT_W-1:0]  bcnt, bcnt_n;
  logic               par_en, par_en_n;
  logic               par_odd, par_odd_n;
  logic               two_stop, two_stop_n;
  logic               perr, perr_n;
  logic               ferr, ferr_n;
  logic               brk_wait, brk_wait_n;
  logic               done_c;
  logic               fe_c;

  logic rx_sync;
  logic samp_stb;
  logic samp_bit;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk          (i_clk),
    .rst_n        (i_reset),
    .baud_tick    (i_baud_tick),
    .rx           (i_rx),
    .clr          (state == IDLE),
    .start_phase  (state == START),
    .rx_sync      (rx_sync),
    .sample_stb_c (samp_stb),
    .sample_bit_c (samp_bit)
  );

  // FSM and frame datapath registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bcnt     <= '0;
      par_en   <= 1'b0;
      par_odd  <= 1'b0;
      two_stop <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      brk_wait <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bcnt     <= bcnt_n;
      par_en   <= par_en_n;
      par_odd  <= par_odd_n;
      two_stop <= two_stop_n;
      perr     <= perr_n;
      ferr     <= ferr_n;
      brk_wait <= brk_wait_n;
    end
  end

  // Next-state and frame checks; done_c marks the final stop sample.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bcnt_n     = bcnt;
    par_en_n   = par_en;
    par_odd_n  = par_odd;
    two_stop_n = two_stop;
    perr_n     = perr;
    ferr_n     = ferr;
    brk_wait_n = brk_wait;
    done_c     = 1'b0;
    fe_c       = ferr;

    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_n    = START;
          par_en_n   = i_parity_en;
          par_odd_n  = i_parity_odd;
          two_stop_n = i_two_stop;
          perr_n     = 1'b0;
          ferr_n     = 1'b0;
          bcnt_n     = '0;
          brk_wait_n = 1'b0;
        end
      end
      START: begin
        if (samp_stb) begin
          state_n = samp_bit ? IDLE : DATA;
          bcnt_n  = '0;
        end
      end
      DATA: begin
        if (samp_stb) begin
          shreg_n = {samp_bit, shreg[DATA_W-1:1]};
          if (bcnt == BCNT_W'(DATA_W - 1)) begin
            bcnt_n  = '0;
            state_n = par_en ? PARITY : STOP;
          end else begin
            bcnt_n = bcnt + BCNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (samp_stb) begin
          perr_n  = parity_err(DATA_W_MAX'(shreg), samp_bit, par_odd);
          state_n = STOP;
        end
      end
      STOP: begin
        if (brk_wait) begin
          if (rx_sync) begin
            brk_wait_n = 1'b0;
            state_n    = IDLE;
          end
        end else if (samp_stb) begin
          fe_c   = ferr | ~samp_bit;
          ferr_n = fe_c;
          if (two_stop && (bcnt == '0)) begin
            bcnt_n = BCNT_W'(1);
          end else begin
            done_c = 1'b1;
            if (fe_c && !rx_sync) brk_wait_n = 1'b1;
            else                  state_n    = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output presentation, handshake and overrun pulse.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      o_busy    <= (state_n != IDLE);
      if (done_c) begin
        if (o_valid && !i_ready) begin
          o_overrun <= 1'b1;
        end else begin
          o_data       <= shreg;
          o_parity_err <= perr;
          o_frame_err  <= fe_c;
          o_valid      <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: scoreboard of expected frames popped on accept.
module tb_uart_rx_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned OS = 16;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_baud_tick = 1'b0;
  logic          i_rx = 1'b1;
  logic          i_parity_en = 1'b0;
  logic          i_parity_odd = 1'b0;
  logic          i_two_stop = 1'b0;
  logic          i_ready = 1'b1;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_parity_err;
  logic          o_frame_err;
  logic          o_overrun;
  logic          o_busy;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   valid_cycles = 0;
  int   busy_cycles = 0;
  int   ovr_cnt = 0;
  int   div = 0;

  uart_rx_ctrl #(.DATA_W(DW), .OVERSAMPLE(OS)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_baud_tick  (i_baud_tick),
    .i_rx         (i_rx),
    .i_parity_en  (i_parity_en),
    .i_parity_odd (i_parity_odd),
    .i_two_stop   (i_two_stop),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Baud tick every 4 clocks.
  always @(posedge i_clk) begin
    if (div == 3) begin
      div         <= 0;
      i_baud_tick <= 1'b1;
    end else begin
      div         <= div + 1;
      i_baud_tick <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: count activity, pop and compare on each accepted frame.
  always @(negedge i_clk) begin
    if (i_reset) begin
      if (o_busy)  busy_cycles++;
      if (o_valid) valid_cycles++;
      if (o_overrun) begin
        ovr_cnt++;
        check("ovr_valid_held", o_valid, 1);
      end
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          check("sb_unexpected_frame", 1, 0);
        end else begin
          e = q.pop_front();
          check("data", o_data, e.d);
          check("parity_err", o_parity_err, e.pe);
          check("frame_err", o_frame_err, e.fe);
        end
      end
    end
  end

  task automatic wait_tick();
    do @(posedge i_clk); while (i_baud_tick !== 1'b1);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    i_rx = b;
    repeat (OS) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par, input logic pbit,
                            input logic s0, input logic s1, input bit two);
    wait_tick();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par) drive_bit(pbit);
    drive_bit(s0);
    if (two) drive_bit(s1);
    i_rx = 1'b1;
    repeat (OS) wait_tick();
  endtask

  initial begin
    int vc0;
    int bc0;
    int oc0;

    // Reset state.
    repeat (5) @(posedge i_clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_errs", {o_parity_err, o_frame_err}, 0);
    i_reset = 1'b1;
    repeat (OS) wait_tick();

    // 8N1 0xA5, single-cycle valid.
    vc0 = valid_cycles;
    q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
    send_frame(8'hA5, 0, 1'b0, 1'b1, 1'b1, 0);
    check("a5_valid_cycles", valid_cycles - vc0, 1);
    check("a5_idle", o_busy, 0);

    // 8E1 0x3C with parity bit 1: even parity wants 0.
    i_parity_en = 1'b1;
    i_parity_odd = 1'b0;
    q.push_back('{d: 8'h3C, pe: 1'b1, fe: 1'b0});
    send_frame(8'h3C, 1, 1'b1, 1'b1, 1'b1, 0);

    // 8O1 0x3C with parity bit 1: correct.
    i_parity_odd = 1'b1;
    q.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
    send_frame(8'h3C, 1, 1'b1, 1'b1, 1'b1, 0);
    i_parity_en = 1'b0;
    i_parity_odd = 1'b0;

    // 0x55 with stop bit low; controller holds until line returns high.
    q.push_back('{d: 8'h55, pe: 1'b0, fe: 1'b1});
    wait_tick();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
    drive_bit(1'b0);
    repeat (3 * OS) wait_tick();
    check("break_busy", o_busy, 1);
    i_rx = 1'b1;
    repeat (OS) wait_tick();
    check("break_released", o_busy, 0);

    // 8N2 with second stop low flags framing error.
    i_two_stop = 1'b1;
    q.push_back('{d: 8'h81, pe: 1'b0, fe: 1'b1});
    send_frame(8'h81, 0, 1'b0, 1'b1, 1'b0, 1);
    i_two_stop = 1'b0;
    check("two_stop_idle", o_busy, 0);

    // 4-tick low glitch: false start, busy only.
    vc0 = valid_cycles;
    bc0 = busy_cycles;
    wait_tick();
    i_rx = 1'b0;
    repeat (4) wait_tick();
    i_rx = 1'b1;
    repeat (OS) wait_tick();
    check("glitch_busy_seen", (busy_cycles - bc0) > 0, 1);
    check("glitch_no_valid", valid_cycles - vc0, 0);
    check("glitch_idle", o_busy, 0);

    // Overrun: two frames with consumer stalled.
    i_ready = 1'b0;
    oc0 = ovr_cnt;
    q.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
    send_frame(8'h11, 0, 1'b0, 1'b1, 1'b1, 0);
    check("ovr_none_yet", ovr_cnt - oc0, 0);
    send_frame(8'h22, 0, 1'b0, 1'b1, 1'b1, 0);
    check("ovr_pulse_count", ovr_cnt - oc0, 1);
    check("ovr_data_held", o_data, 8'h11);
    check("ovr_valid_held", o_valid, 1);
    i_ready = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    check("ovr_drained", o_valid, 0);

    // Reset mid-DATA of 0xFF, then clean 0x0F.
    wait_tick();
    drive_bit(1'b0);
    repeat (3) drive_bit(1'b1);
    i_reset = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_valid", o_valid, 0);
    i_reset = 1'b1;
    repeat (2 * OS) wait_tick();
    check("midrst_idle_after", o_busy, 0);
    q.push_back('{d: 8'h0F, pe: 1'b0, fe: 1'b0});
    send_frame(8'h0F, 0, 1'b0, 1'b1, 1'b1, 0);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-tick low glitch exactly at mid-bit of bit0 is voted out.
    q.push_back('{d: 8'h0F, pe: 1'b0, fe: 1'b0});
    wait_tick();
    drive_bit(1'b0);
    i_rx = 1'b1;
    repeat (OS / 2 - 1) wait_tick();
    i_rx = 1'b0;
    wait_tick();
    i_rx = 1'b1;
    repeat (OS / 2) wait_tick();
    for (int i = 1; i < 8; i++) drive_bit(i < 4 ? 1'b1 : 1'b0);
    drive_bit(1'b1);
    repeat (OS) wait_tick();
`endif

    // Drain scoreboard with a bounded wait.
    for (int n = 0; n < 2000 && q.size() != 0; n++) @(posedge i_clk);
    check("sb_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
